// File: rtl/fma_sum_norm_pipe.sv
// fma16 sum/normalise pipeline: stage 1 adds product and aligned addend,
// stage 2 left-normalises the magnitude and derives the result exponent.
module fma_sum_norm_pipe #(
  parameter int SW = 35,
  parameter int EW = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [21:0]          Pm,
  input  logic                 Ps,
  input  logic                 Zs,
  input  logic signed [EW-1:0] BaseE,
  input  logic [SW-2:0]        Am,
  input  logic                 ASticky,
  input  logic                 KillProd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SW-1:0]        Mm,
  output logic signed [EW-1:0] Me,
  output logic                 Ss,
  output logic                 Sticky,
  output logic                 Zero
);

  localparam int W1 = SW + 1;
  localparam int LW = $clog2(SW + 1);

  logic          ready_en;
  logic          s1_valid, s2_valid;
  logic          s1_adv, s2_adv, accept;
  logic [SW-1:0] s1_sum;
  logic          s1_sgn, s1_sticky, s1_zsgn;
  logic [EW-1:0] s1_base;

  assign s2_adv    = ~s2_valid | out_ready;
  assign s1_adv    = ~s1_valid | s2_adv;
  assign in_ready  = ready_en & s1_adv;
  assign accept    = in_valid & in_ready;
  assign out_valid = s2_valid;

  // Held low through reset so nothing is accepted until the first clean edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  // Stage 1: the subtract is done one bit wider so the top bit flags a negative sum.
  logic          inva, neg, sgn_c;
  logic [W1-1:0] pme, ame, raw;
  logic [SW-1:0] sum_c;

  always_comb begin
    inva  = Ps ^ Zs;
    pme   = KillProd ? '0 : W1'(Pm);
    ame   = W1'(Am);
    raw   = pme + (inva ? ~ame : ame) + W1'(inva & ~(ASticky & ~KillProd));
    neg   = inva & raw[SW];
    sum_c = neg ? -raw[SW-1:0] : raw[SW-1:0];
    sgn_c = KillProd ? Zs : (Ps ^ neg);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s1_sgn    <= 1'b0;
      s1_sticky <= 1'b0;
      s1_zsgn   <= 1'b0;
      s1_base   <= '0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_sum    <= sum_c;
        s1_sgn    <= sgn_c;
        s1_sticky <= ASticky;
        s1_zsgn   <= Ps & Zs;
        s1_base   <= BaseE;
      end
    end
  end

  // Stage 2: leading-zero count, normalise, exponent of the new MSB.
  logic [LW-1:0] lzc;
  logic          zero_c;
  logic [SW-1:0] mm_c;
  logic [EW-1:0] me_c;
  logic          ss_c;

  always_comb begin
    lzc = LW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (s1_sum[i]) lzc = LW'(SW - 1 - i);
    end
    zero_c = ~(|s1_sum) & ~s1_sticky;
    mm_c   = s1_sum << lzc;
    me_c   = zero_c ? '0 : (s1_base + EW'(14) - EW'(lzc));
    ss_c   = zero_c ? s1_zsgn : s1_sgn;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      Mm       <= '0;
      Me       <= '0;
      Ss       <= 1'b0;
      Sticky   <= 1'b0;
      Zero     <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        Mm     <= mm_c;
        Me     <= me_c;
        Ss     <= ss_c;
        Sticky <= s1_sticky;
        Zero   <= zero_c;
      end
    end
  end

endmodule
